// File: rtl/encode_seq_if.sv
// Request/response bundle for the sequential priority encoder.
// The master modport is the encoder side; slave is the request source / consumer side.
interface encode_seq_if #(
    parameter int N = 4
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic [N-1:0] pending;
    logic         idle;

    modport master (
        input  req,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending,
        output idle
    );

    modport slave (
        output req,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending,
        input  idle
    );
endinterface

// File: rtl/encode_seq.sv
// Sequential priority encoder: merges request strobes into a pending set and issues
// one binary index per transfer, highest index first. Optional ENCODE_OVF_EN adds a sticky lost-request flag.
module encode_seq #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    encode_seq_if.master  bus
`ifdef ENCODE_OVF_EN
    ,
    output logic          ovf
`endif
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_code_q,  out_code_d;
    logic [N-1:0] pending_q,   pending_d;

    logic [N-1:0] eff;
    logic [N-1:0] top_onehot;
    logic [W-1:0] top_idx;
    logic         eff_any;
    logic         slot_free;

    assign eff       = pending_q | bus.req;
    assign eff_any   = |eff;
    assign slot_free = !out_valid_q || bus.out_ready;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eff[i]) begin
                top_idx = W'(i);
            end
        end
    end

    assign top_onehot = N'(1) << top_idx;

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        pending_d   = eff;
        if (slot_free) begin
            if (eff_any) begin
                out_valid_d = 1'b1;
                out_code_d  = top_idx;
                pending_d   = eff & ~top_onehot;
            end else begin
                out_valid_d = 1'b0;
                pending_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            pending_q   <= pending_d;
        end
    end

`ifdef ENCODE_OVF_EN
    logic ovf_q, ovf_d;

    // A strobe on a bit that is already waiting merges away; remember that it happened.
    always_comb begin
        ovf_d = ovf_q | (|(bus.req & pending_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.pending   = pending_q;
    assign bus.idle      = !out_valid_q && (pending_q == '0);
endmodule

// File: tb/tb_encode_seq.sv
// Bench for encode_seq: scenario tasks check registered state each cycle, while a
// monitor pops expected codes from a scoreboard queue on every accepted transfer.
module tb_encode_seq;
    localparam int N = 4;
    localparam int W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];

    encode_seq_if #(.N(N)) bus ();

`ifdef ENCODE_OVF_EN
    logic ovf;
`endif

    encode_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ENCODE_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status word: {out_valid, out_code, pending, idle}
    function automatic logic [7:0] status();
        return {bus.out_valid, bus.out_code, bus.pending, bus.idle};
    endfunction

    function automatic logic [7:0] mk(input logic v, input logic [1:0] c,
                                      input logic [3:0] p, input logic i);
        return {v, c, p, i};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted transfer must match the next expected code.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: got code %0d, required no transfer", bus.out_code);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.out_code !== e) begin
                    errors++;
                    $display("FAIL accept_code: got %0d required %0d", bus.out_code, e);
                end else begin
                    $display("accept code %0d", bus.out_code);
                end
            end
        end
    end

    task automatic test_reset();
        logic [7:0] got, exp;
        rst_n = 1'b0;
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = status(); exp = mk(1'b0, 2'd0, 4'b0000, 1'b1);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_state: got %b required %b", got, exp);
            end
`ifdef ENCODE_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf: got %b required 0", ovf);
            end
`endif
        end
        rst_n = 1'b1;
        bus.req = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.idle !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_idle: got idle %b valid %b required idle 1 valid 0",
                         bus.idle, bus.out_valid);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] got, exp;
        bus.out_ready = 1'b1;
        bus.req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        bus.req = '0;
        got = status(); exp = mk(1'b1, 2'd2, 4'b0000, 1'b0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_issue: got %b required %b", got, exp);
        end
        step();
        got = status(); exp = mk(1'b0, 2'd2, 4'b0000, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_drain: got %b required %b", got, exp);
        end
    endtask

    task automatic test_multi_hot();
        logic [7:0] got;
        logic [7:0] exp_tab [4];
        exp_tab[0] = mk(1'b1, 2'd3, 4'b0011, 1'b0);
        exp_tab[1] = mk(1'b1, 2'd1, 4'b0001, 1'b0);
        exp_tab[2] = mk(1'b1, 2'd0, 4'b0000, 1'b0);
        exp_tab[3] = mk(1'b0, 2'd0, 4'b0000, 1'b1);
        bus.out_ready = 1'b1;
        bus.req = 4'b1011;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.req = '0;
            got = status();
            checks++;
            if (got !== exp_tab[i]) begin
                errors++;
                $display("FAIL multi_hot_cycle%0d: got %b required %b", i, got, exp_tab[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got, exp;
        bus.out_ready = 1'b0;
        bus.req = 4'b0110;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.req = '0;
            got = status(); exp = mk(1'b1, 2'd2, 4'b0010, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got %b required %b", i, got, exp);
            end
        end
        bus.out_ready = 1'b1;
        step();
        got = status(); exp = mk(1'b1, 2'd1, 4'b0000, 1'b0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backpressure_release: got %b required %b", got, exp);
        end
        step();
        got = status(); exp = mk(1'b0, 2'd1, 4'b0000, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backpressure_drain: got %b required %b", got, exp);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        logic [7:0] exp_tab [5];
        logic       ovf_tab [5];
        exp_tab[0] = mk(1'b1, 2'd0, 4'b0000, 1'b0); ovf_tab[0] = 1'b0;
        exp_tab[1] = mk(1'b1, 2'd0, 4'b0001, 1'b0); ovf_tab[1] = 1'b0;
        exp_tab[2] = mk(1'b1, 2'd0, 4'b0001, 1'b0); ovf_tab[2] = 1'b1;
        exp_tab[3] = mk(1'b1, 2'd0, 4'b0000, 1'b0); ovf_tab[3] = 1'b1;
        exp_tab[4] = mk(1'b0, 2'd0, 4'b0000, 1'b1); ovf_tab[4] = 1'b1;
        bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) begin
                bus.req = '0;
                bus.out_ready = 1'b1;
            end
            got = status();
            checks++;
            if (got !== exp_tab[i]) begin
                errors++;
                $display("FAIL overflow_cycle%0d: got %b required %b", i, got, exp_tab[i]);
            end
`ifdef ENCODE_OVF_EN
            checks++;
            if (ovf !== ovf_tab[i]) begin
                errors++;
                $display("FAIL overflow_flag%0d: got %b required %b", i, ovf, ovf_tab[i]);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] got, exp;
        bus.out_ready = 1'b0;
        bus.req = 4'b1011;
        step();
        bus.req = '0;
        got = status(); exp = mk(1'b1, 2'd3, 4'b0011, 1'b0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midreset_first: got %b required %b", got, exp);
        end
        rst_n = 1'b0;
        step();
        got = status(); exp = mk(1'b0, 2'd0, 4'b0000, 1'b1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midreset_cleared: got %b required %b", got, exp);
        end
`ifdef ENCODE_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ovf: got %b required 0", ovf);
        end
`endif
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.idle !== 1'b1) begin
                errors++;
                $display("FAIL midreset_quiet%0d: got valid %b idle %b required valid 0 idle 1",
                         i, bus.out_valid, bus.idle);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] req_tab  [5];
        logic [7:0]   exp_tab  [5];
        req_tab[0] = 4'b1000; exp_tab[0] = mk(1'b1, 2'd3, 4'b0000, 1'b0);
        req_tab[1] = 4'b0100; exp_tab[1] = mk(1'b1, 2'd2, 4'b0000, 1'b0);
        req_tab[2] = 4'b0011; exp_tab[2] = mk(1'b1, 2'd1, 4'b0001, 1'b0);
        req_tab[3] = 4'b0000; exp_tab[3] = mk(1'b1, 2'd0, 4'b0000, 1'b0);
        req_tab[4] = 4'b0000; exp_tab[4] = mk(1'b0, 2'd0, 4'b0000, 1'b1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req = req_tab[i];
            step();
            checks++;
            if (status() !== exp_tab[i]) begin
                errors++;
                $display("FAIL back_to_back%0d: got %b required %b", i, status(), exp_tab[i]);
            end
        end
        bus.req = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi_hot();
        test_backpressure();
        test_overflow();
        test_reset_mid_op();
        test_back_to_back();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding codes required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
